// File: rtl/gray_bin_codec_if.sv
// rtl/gray_bin_codec_if.sv - handshake bundle for the Gray/binary converter
//
// Ports carried:
//   in_valid/in_ready/in_mode/in_data     source word handshake
//   out_valid/out_ready/out_data/out_mode result handshake
// slave  : the converter side
// master : the producer/consumer side
interface gray_bin_codec_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_mode;

    modport slave (
        input  in_valid,
        input  in_mode,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_mode
    );

    modport master (
        output in_valid,
        output in_mode,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_mode
    );
endinterface

// File: rtl/gray_bin_codec.sv
// rtl/gray_bin_codec.sv - bit-serial Gray/binary code converter
//
// Converts one word at a time, MSB first, one bit per clock.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   gray_bin_codec_if.slave: in_* accepts {mode, word}, out_* returns
//         {mode, converted word}; mode 0 = Gray->binary, 1 = binary->Gray
//   busy  high while a word is being converted or waiting to be taken
module gray_bin_codec #(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    gray_bin_codec_if.slave bus,
    output logic            busy
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] src;
    logic             mode;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] out_data_r;
    logic             out_mode_r;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             busy_c;

    // Shifting right supplies the "bit above" for every index, with the
    // missing bit WIDTH reading as 0 in both directions.  res is cleared on
    // accept and filled from the top, so res[idx+1] is always final here.
    logic [WIDTH-1:0] src_shift;
    logic [WIDTH-1:0] res_shift;
    assign src_shift = src >> 1;
    assign res_shift = res >> 1;

    always_comb begin
        res_next      = res;
        res_next[idx] = src[idx] ^ (mode ? src_shift[idx] : res_shift[idx]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                busy_c = 1'b1;
                if (idx == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy_c      = 1'b1;
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src        <= '0;
            mode       <= 1'b0;
            res        <= '0;
            idx        <= IDX_TOP;
            out_data_r <= '0;
            out_mode_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        src  <= bus.in_data;
                        mode <= bus.in_mode;
                        res  <= '0;
                        idx  <= IDX_TOP;
                    end
                end
                S_BUSY: begin
                    res <= res_next;
                    if (idx == '0) begin
                        // Output copy is kept apart from res so the last
                        // result survives the next accept's clearing of res.
                        out_data_r <= res_next;
                        out_mode_r <= mode;
                    end else begin
                        idx <= idx - IDX_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_r;
    assign bus.out_mode  = out_mode_r;
    assign busy          = busy_c;
endmodule

// File: tb/tb_gray_bin_codec.sv
// tb/tb_gray_bin_codec.sv - self-checking bench for gray_bin_codec
module tb_gray_bin_codec;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy4;
    logic busy8;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    gray_bin_codec_if #(.WIDTH(4)) bus4 ();
    gray_bin_codec_if #(.WIDTH(8)) bus8 ();

    gray_bin_codec #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave), .busy(busy4));
    gray_bin_codec #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave), .busy(busy8));

    typedef struct {
        logic       m;
        logic [3:0] d;
        logic [3:0] e;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: Gray code is v xor v/2; binary is the xor of all
    // right shifts of the Gray word.
    function automatic logic [31:0] m_b2g(input logic [31:0] v);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [31:0] m_g2b(input logic [31:0] g);
        logic [31:0] b;
        b = 0;
        for (int k = 0; k < 32; k++) b = b ^ (g >> k);
        return b;
    endfunction

    function automatic logic [31:0] model(input logic m, input logic [31:0] v, input int w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (m ? m_b2g(v & mask) : m_g2b(v & mask)) & mask;
    endfunction

    task automatic run4(input logic m, input logic [3:0] d, input int stall,
                        output logic [3:0] r, output logic rm, output int lat);
        int n;
        bit ok;
        @(negedge clk);
        n = 0;
        while (!bus4.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus4.in_ready) check("run4_ready_timeout", 0, 1);
        bus4.in_valid  = 1'b1;
        bus4.in_mode   = m;
        bus4.in_data   = d;
        bus4.out_ready = (stall == 0);
        lat = 0;
        ok  = 1'b1;
        do begin
            @(negedge clk);
            bus4.in_valid = 1'b0;
            bus4.in_data  = 4'($urandom);
            lat++;
            if (!bus4.out_valid && (bus4.in_ready || !busy4)) ok = 1'b0;
        end while (!bus4.out_valid && lat < 50);
        check("run4_busy_flags", 32'(ok), 1);
        r  = bus4.out_data;
        rm = bus4.out_mode;
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            check("run4_stall_hold", 32'(bus4.out_data), 32'(r));
            bus4.out_ready = 1'b1;
        end
    endtask

    task automatic run8(input logic m, input logic [7:0] d, input int stall,
                        output logic [7:0] r, output logic rm, output int lat);
        int n;
        bit ok;
        @(negedge clk);
        n = 0;
        while (!bus8.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus8.in_ready) check("run8_ready_timeout", 0, 1);
        bus8.in_valid  = 1'b1;
        bus8.in_mode   = m;
        bus8.in_data   = d;
        bus8.out_ready = (stall == 0);
        lat = 0;
        ok  = 1'b1;
        do begin
            @(negedge clk);
            bus8.in_valid = 1'b0;
            bus8.in_data  = 8'($urandom);
            lat++;
            if (!bus8.out_valid && (bus8.in_ready || !busy8)) ok = 1'b0;
        end while (!bus8.out_valid && lat < 50);
        check("run8_busy_flags", 32'(ok), 1);
        r  = bus8.out_data;
        rm = bus8.out_mode;
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            check("run8_stall_hold", 32'(bus8.out_data), 32'(r));
            bus8.out_ready = 1'b1;
        end
    endtask

    initial begin
        vec_t       tbl[7];
        logic [3:0] r4, g4, pg4, wd[6];
        logic [7:0] r8, g8, pg8, rd;
        logic       rm, rm2, wm[6], rmode;
        int         lat, n, k, got, last_t, t;
        bit         ok, pend;

        tbl[0] = '{1'b0, 4'b0110, 4'b0100};
        tbl[1] = '{1'b0, 4'b1000, 4'b1111};
        tbl[2] = '{1'b1, 4'b1011, 4'b1110};
        tbl[3] = '{1'b1, 4'b0111, 4'b0100};
        tbl[4] = '{1'b0, 4'b0000, 4'b0000};
        tbl[5] = '{1'b1, 4'b1111, 4'b1000};
        tbl[6] = '{1'b0, 4'b1111, 4'b1010};

        bus4.in_valid = 1'b0; bus4.in_mode = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.in_mode = 1'b0; bus8.in_data = '0; bus8.out_ready = 1'b1;

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_in_ready", 32'(bus4.in_ready), 1);
        check("rst_out_valid", 32'(bus4.out_valid), 0);
        check("rst_busy", 32'(busy4), 0);
        check("rst_out_data", 32'(bus4.out_data), 0);
        check("rst_out_mode", 32'(bus4.out_mode), 0);
        check("rst8_out_data", 32'(bus8.out_data), 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            run4(tbl[i].m, tbl[i].d, 0, r4, rm, lat);
            check("vec_latency", 32'(lat), 5);
            check("vec_data", 32'(r4), 32'(tbl[i].e));
            check("vec_mode", 32'(rm), 32'(tbl[i].m));
        end

        // Backpressure in DONE with a stray input pulse
        @(negedge clk);
        bus4.in_valid = 1'b1; bus4.in_mode = 1'b1; bus4.in_data = 4'b1011; bus4.out_ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            bus4.in_valid = 1'b0;
            n++;
        end while (!bus4.out_valid && n < 50);
        check("bp_reach_done", 32'(bus4.out_valid), 1);
        for (int c = 0; c < 6; c++) begin
            if (c == 2) begin
                bus4.in_valid = 1'b1; bus4.in_mode = 1'b0; bus4.in_data = 4'b0001;
            end else begin
                bus4.in_valid = 1'b0;
            end
            @(negedge clk);
            check("bp_data_stable", 32'(bus4.out_data), 32'b1110);
            check("bp_in_ready_low", 32'(bus4.in_ready), 0);
            check("bp_busy", 32'(busy4), 1);
            check("bp_valid_held", 32'(bus4.out_valid), 1);
        end
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        @(negedge clk);
        check("bp_exit_in_ready", 32'(bus4.in_ready), 1);
        check("bp_exit_valid", 32'(bus4.out_valid), 0);
        check("bp_data_holds", 32'(bus4.out_data), 32'b1110);
        ok = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus4.out_valid || !bus4.in_ready) ok = 1'b0;
        end
        check("bp_pulse_not_accepted", 32'(ok), 1);

        // Asynchronous reset two cycles after accept
        bus4.in_valid = 1'b1; bus4.in_mode = 1'b0; bus4.in_data = 4'b1000;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstmid_out_valid", 32'(bus4.out_valid), 0);
        check("rstmid_out_data", 32'(bus4.out_data), 0);
        check("rstmid_in_ready", 32'(bus4.in_ready), 1);
        check("rstmid_busy", 32'(busy4), 0);
        @(negedge clk);
        rst = 1'b0;
        run4(1'b0, 4'b1000, 0, r4, rm, lat);
        check("rstmid_after_data", 32'(r4), 32'b1111);
        check("rstmid_after_lat", 32'(lat), 5);

        // Exhaustive round trip, WIDTH=4
        pg4 = '0;
        for (int v = 0; v < 16; v++) begin
            run4(1'b1, 4'(v), 0, g4, rm, lat);
            check("rt4_gray", 32'(g4), model(1'b1, 32'(v), 4));
            if (v > 0) check("rt4_one_bit", 32'($countones(g4 ^ pg4)), 1);
            pg4 = g4;
            run4(1'b0, g4, 0, r4, rm2, lat);
            check("rt4_back", 32'(r4), 32'(v));
            check("rt4_mode", 32'(rm2), 0);
        end

        // Exhaustive round trip, WIDTH=8, with random output stalls
        pg8 = '0;
        for (int v = 0; v < 256; v++) begin
            run8(1'b1, 8'(v), int'($urandom_range(0, 2)), g8, rm, lat);
            check("rt8_gray", 32'(g8), model(1'b1, 32'(v), 8));
            check("rt8_lat", 32'(lat), 9);
            if (v > 0) check("rt8_one_bit", 32'($countones(g8 ^ pg8)), 1);
            pg8 = g8;
            run8(1'b0, g8, 0, r8, rm2, lat);
            check("rt8_back", 32'(r8), 32'(v));
        end

        // Random words, random modes, WIDTH=8
        for (int i = 0; i < 40; i++) begin
            rd    = 8'($urandom);
            rmode = 1'($urandom);
            run8(rmode, rd, int'($urandom_range(0, 3)), r8, rm, lat);
            check("rnd8_data", 32'(r8), model(rmode, 32'(rd), 8));
            check("rnd8_mode", 32'(rm), 32'(rmode));
        end

        // Throughput: in_valid and out_ready held high
        for (int i = 0; i < 6; i++) begin
            wd[i] = 4'($urandom);
            wm[i] = 1'($urandom);
        end
        @(negedge clk);
        @(negedge clk);
        bus4.out_ready = 1'b1;
        bus4.in_valid  = 1'b1;
        bus4.in_data   = wd[0];
        bus4.in_mode   = wm[0];
        k = 0; got = 0; last_t = 0; t = 0;
        pend = bus4.in_ready;
        while (got < 6 && t < 200) begin
            @(negedge clk);
            t++;
            if (bus4.out_valid) begin
                check("tput_data", 32'(bus4.out_data), model(wm[got], 32'(wd[got]), 4));
                check("tput_mode", 32'(bus4.out_mode), 32'(wm[got]));
                if (got > 0) check("tput_interval", 32'(cyc - last_t), 6);
                last_t = cyc;
                got++;
            end
            if (pend) begin
                k++;
                if (k < 6) begin
                    bus4.in_data = wd[k];
                    bus4.in_mode = wm[k];
                end else begin
                    bus4.in_valid = 1'b0;
                end
            end
            pend = bus4.in_ready && bus4.in_valid;
        end
        if (got < 6) check("tput_timeout", 32'(got), 6);
        bus4.in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gray_bin_codec.md
# gray_bin_codec

Parametrised, bit-serial Gray/binary code converter with valid/ready handshakes on input and output. Each accepted word carries a per-word mode bit: Gray-to-binary or binary-to-Gray. The word is processed MSB-first, one bit per clock, by a three-state FSM. The block serves as the shared code-conversion engine for counter, pointer and encoder paths that need either direction at arbitrary width.

## Interface
- WIDTH, 4, data word width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept a word; high only in IDLE.
- in_mode  in  1  0 = Gray→binary, 1 = binary→Gray; sampled with in_data.
- in_data  in  WIDTH  source word.
- out_valid  out  1  result present; high only in DONE.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  converted word.
- out_mode  out  1  mode used for out_data.
- busy  out  1  high in BUSY or DONE.

## Operation
- Registers:
  - src[WIDTH-1:0] and mode, both latched on accept.
  - res[WIDTH-1:0], the result.
  - idx, of $clog2(WIDTH) bits, the current bit index.
  - state ∈ {IDLE, BUSY, DONE}.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: src←in_data, mode←in_mode, res←0, idx←WIDTH-1, go to BUSY.
  - Otherwise hold.
- BUSY: each cycle writes res[idx] and decrements idx.
  - mode 0 (Gray→binary): res[idx] = src[idx] ^ res[idx+1], with res[WIDTH] taken as 0.
  - mode 1 (binary→Gray): res[idx] = src[idx] ^ src[idx+1], with src[WIDTH] taken as 0.
  - When idx==0, write bit 0 and go to DONE. idx never wraps.
- DONE:
  - out_valid=1. out_data=res and out_mode=mode, both stable while out_valid && !out_ready.
  - On out_ready, go to IDLE.
- in_valid outside IDLE is ignored. There is no buffering and no overlap of words.
- out_data holds the last result after DONE exits and is only cleared by reset.
- in_data and in_mode are don't-care when in_valid=0.
- Reset (any state, any time) forces all of the following; an in-flight word is discarded:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - out_data=0, out_mode=0, src=0, res=0, idx=WIDTH-1.

## Timing
- Accept edge E0: the edge with in_valid && in_ready.
- Edges E1..E_WIDTH compute bits WIDTH-1..0. BUSY lasts exactly WIDTH cycles.
- out_valid rises after edge E_WIDTH, i.e. WIDTH+1 edges after accept.
- With out_ready held high:
  - DONE lasts 1 cycle and IDLE lasts at least 1 cycle.
  - Minimum issue interval is WIDTH+2 cycles.
- in_ready falls combinationally-from-state in the cycle after E0. It rises in the cycle after the output handshake edge.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid or out_ready to any output.
- Simultaneous in_valid and out_ready in DONE: only the output handshake completes; the input is accepted on a later IDLE cycle.

## Test plan
- WIDTH=4, Gray→binary, in_data=4'b0110, out_ready=1 -> out_valid asserts 5 edges after accept with out_data=4'b0100 and out_mode=0. Also 4'b1000 -> 4'b1111.
- WIDTH=4, binary→Gray, in_data=4'b1011 -> out_data=4'b1110 and out_mode=1. Also 4'b0111 -> 4'b0100.
- Backpressure: hold out_ready=0 for 6 cycles in DONE, and pulse in_valid with 4'b0001 -> out_data is stable, in_ready=0 throughout, the pulsed word is not accepted, and busy=1.
- Exhaustive round trip, WIDTH=4 and WIDTH=8: feed every value v in binary→Gray mode, then feed the result in Gray→binary mode -> the final out_data equals v. Gray outputs of consecutive v differ in exactly 1 bit.
- Reset mid-BUSY: assert rst asynchronously 2 cycles after accept -> the same cycle shows out_valid=0, out_data=0, in_ready=1. A word accepted after release converts correctly.
- Throughput: in_valid and out_ready held high with WIDTH=4 -> one result every 6 cycles, results in order.
